// File: rtl/rtf65002_seqalu.sv
// rtf65002_seqalu: sequential ALU with start/done handshake; divide/modulo present when RTF65002_DIVMOD_EN is defined.
module rtf65002_seqalu #(
  parameter int WID = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [3:0]     op,
  input  logic           df,
  input  logic           cf,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [WID:0]   res,
  output logic [WID-1:0] res_hi,
  output logic           dbz
);
  localparam int LW = $clog2(WID);
  localparam int CW = LW + 1;
`ifdef RTF65002_DIVMOD_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, rn;
  logic [WID-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, res_hi_q, res_hi_d, rol, ror;
  logic [WID:0] res_q, res_d, sc_res, mul_sum, shl, shr;
  logic busy_q, busy_d, done_q, done_d;
  logic [LW-1:0] n;
  always_comb begin
    n = b[LW-1:0];
    rn = CW'(WID) - {1'b0, n};
    shl = {1'b0, a} << n;
    shr = {a, 1'b0} >> n;
    rol = (a << n) | (a >> rn);
    ror = (a >> n) | (a << rn);
    case (op)
      4'h0:    sc_res = {1'b0, a} + {1'b0, b} + (WID+1)'(df & cf);
      4'h1:    sc_res = {1'b0, a} - {1'b0, b} - (WID+1)'(df & ~cf);
      4'h2:    sc_res = {1'b0, a & b};
      4'h3:    sc_res = {1'b0, a | b};
      4'h4:    sc_res = {1'b0, a ^ b};
      4'h5:    sc_res = shl;
      4'h6:    sc_res = {shr[0], shr[WID:1]};
      4'h7:    sc_res = {(n != '0) & rol[0], rol};
      4'h8:    sc_res = {(n != '0) & ror[WID-1], ror};
      default: sc_res = '0;
    endcase
  end
`ifdef RTF65002_DIVMOD_EN
  logic md_q, md_d, dbz_q, dbz_d, div_ok;
  logic [WID:0] div_sh;
  logic [WID-1:0] div_r, div_qt;
  always_comb begin
    div_sh = {hi_q, lo_q[WID-1]};
    div_ok = div_sh >= {1'b0, m_q};
    div_r = div_ok ? WID'(div_sh - {1'b0, m_q}) : div_sh[WID-1:0];
    div_qt = {lo_q[WID-2:0], div_ok};
  end
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    m_d = m_q;
    res_d = res_q;
    res_hi_d = res_hi_q;
`ifdef RTF65002_DIVMOD_EN
    md_d = md_q;
    dbz_d = dbz_q;
`endif
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    case (state_q)
      S_IDLE: if (ld) begin
        cnt_d = CW'(WID);
        hi_d = '0;
        m_d = a;
        lo_d = b;
        if (op == 4'h9) state_d = S_MUL;
`ifdef RTF65002_DIVMOD_EN
        else if (op[3:1] == 3'b101 && b != '0) begin
          state_d = S_DIV;
          md_d = op[0];
          m_d = b;
          lo_d = a;
        end else if (op[3:1] == 3'b101) begin
          state_d = S_FIN;
          dbz_d = 1'b1;
          res_d = op[0] ? {1'b0, a} : {1'b0, {WID{1'b1}}};
          res_hi_d = op[0] ? {WID{1'b1}} : a;
        end
`endif
        else begin
          state_d = S_FIN;
          res_d = sc_res;
          res_hi_d = '0;
`ifdef RTF65002_DIVMOD_EN
          dbz_d = 1'b0;
`endif
        end
      end
      S_MUL: begin
        hi_d = mul_sum[WID:1];
        lo_d = {mul_sum[0], lo_q[WID-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIN;
          res_d = {1'b0, lo_d};
          res_hi_d = hi_d;
`ifdef RTF65002_DIVMOD_EN
          dbz_d = 1'b0;
`endif
        end
      end
`ifdef RTF65002_DIVMOD_EN
      S_DIV: begin
        hi_d = div_r;
        lo_d = div_qt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIN;
          dbz_d = 1'b0;
          res_d = md_q ? {1'b0, div_r} : {1'b0, div_qt};
          res_hi_d = md_q ? div_qt : div_r;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_FIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      res_q <= '0;
      res_hi_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef RTF65002_DIVMOD_EN
      md_q <= 1'b0;
      dbz_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
      res_q <= res_d;
      res_hi_q <= res_hi_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef RTF65002_DIVMOD_EN
      md_q <= md_d;
      dbz_q <= dbz_d;
`endif
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign res = res_q;
  assign res_hi = res_hi_q;
endmodule

// File: tb/tb_rtf65002_seqalu.sv
// tb_rtf65002_seqalu: scoreboard bench for rtf65002_seqalu (WID=32); divide vectors selected by RTF65002_DIVMOD_EN.
module tb_rtf65002_seqalu;
  localparam int W = 32;
  logic clk = 0, rst = 1, ld = 0, df = 0, cf = 0;
  logic [3:0] op = 0;
  logic [W-1:0] a = 0, b = 0;
  logic busy, done, dbz;
  logic [W:0] res;
  logic [W-1:0] res_hi;
  int checks = 0, errors = 0, cyc = 0;
  logic [W:0] q_res[$];
  logic [W-1:0] q_hi[$];
  logic q_dbz[$];
  int q_cyc[$], q_lat[$];
  string q_nm[$];

  rtf65002_seqalu #(.WID(W)) dut (
    .clk(clk), .rst(rst), .ld(ld), .op(op), .df(df), .cf(cf), .a(a), .b(b),
    .busy(busy), .done(done), .res(res), .res_hi(res_hi), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (done) begin
    if (q_res.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
    else begin
      string nm;
      int lat;
      nm = q_nm.pop_front();
      lat = cyc - q_cyc.pop_front() + 1;
      chk({nm, "_res"}, 64'(res), 64'(q_res.pop_front()));
      chk({nm, "_res_hi"}, 64'(res_hi), 64'(q_hi.pop_front()));
      chk({nm, "_dbz"}, 64'(dbz), 64'(q_dbz.pop_front()));
      chk({nm, "_lat"}, 64'(lat), 64'(q_lat.pop_front()));
    end
  end

  task automatic expect_rsp(input logic [W:0] er, input logic [W-1:0] eh, input logic ez, input int el, input string nm);
    q_res.push_back(er);
    q_hi.push_back(eh);
    q_dbz.push_back(ez);
    q_lat.push_back(el);
    q_nm.push_back(nm);
    q_cyc.push_back(cyc + 1);
  endtask

  task automatic drain();
    int t = 0;
    while (q_res.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      chk("timeout_pending", 64'(q_res.size()), 64'd0);
      q_res.delete(); q_hi.delete(); q_dbz.delete(); q_lat.delete(); q_nm.delete(); q_cyc.delete();
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic d, input logic c);
    op = o; a = aa; b = bb; df = d; cf = c; ld = 1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic d, input logic c,
                       input logic [W:0] er, input logic [W-1:0] eh, input logic ez, input int el, input string nm);
    @(negedge clk);
    drive(o, aa, bb, d, c);
    expect_rsp(er, eh, ez, el, nm);
    @(negedge clk);
    ld = 0; a = ~aa; b = ~bb; cf = ~c;
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_res_hi", 64'(res_hi), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    issue(4'h0, 32'hFFFFFFFF, 32'h1, 1, 1, 33'h1_00000001, 0, 0, 1, "add_dfcf");
    issue(4'h0, 32'hFFFFFFFF, 32'h1, 0, 1, 33'h1_00000000, 0, 0, 1, "add_nodf");
    issue(4'h1, 32'h5, 32'h7, 0, 0, 33'h1_FFFFFFFE, 0, 0, 1, "sub_borrow");
    issue(4'h1, 32'h7, 32'h5, 1, 0, 33'h0_00000001, 0, 0, 1, "sub_dfborrow");
    issue(4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 33'h0_F000F000, 0, 0, 1, "and");
    issue(4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 33'h0_FFF0FFF0, 0, 0, 1, "or");
    issue(4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 33'h0_0FF00FF0, 0, 0, 1, "eor");
    issue(4'h5, 32'h80000001, 32'h1, 0, 0, 33'h1_00000002, 0, 0, 1, "asl1");
    issue(4'h5, 32'h80000001, 32'h21, 0, 0, 33'h1_00000002, 0, 0, 1, "asl_b21");
    issue(4'h6, 32'h80000001, 32'h0, 0, 0, 33'h0_80000001, 0, 0, 1, "lsr0");
    issue(4'h6, 32'h80000001, 32'h1, 0, 0, 33'h1_40000000, 0, 0, 1, "lsr1");
    issue(4'h8, 32'h80000009, 32'h4, 0, 0, 33'h1_98000000, 0, 0, 1, "ror4");
    issue(4'h7, 32'h80000001, 32'h4, 0, 0, 33'h0_00000018, 0, 0, 1, "rol4");
    issue(4'hC, 32'h12345678, 32'h9, 0, 0, 33'h0, 0, 0, 1, "op_c");
    issue(4'h9, 32'h00010000, 32'h00010000, 0, 0, 33'h0, 32'h1, 0, 33, "mul_2p32");

    @(negedge clk);
    drive(4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    expect_rsp(33'h0_00000001, 32'hFFFFFFFE, 0, 33, "mul_max");
    @(negedge clk);
    ld = 0;
    repeat (8) @(negedge clk);
    drive(4'h0, 32'h5, 32'h5, 0, 0);
    @(negedge clk);
    ld = 0;
    drain();

`ifdef RTF65002_DIVMOD_EN
    issue(4'hA, 32'd100, 32'd7, 0, 0, 33'd14, 32'd2, 0, 33, "div");
    issue(4'hB, 32'd100, 32'd7, 0, 0, 33'd2, 32'd14, 0, 33, "mod");
    issue(4'hA, 32'd9, 32'd0, 0, 0, 33'h0_FFFFFFFF, 32'd9, 1, 1, "div_zero");
    issue(4'hB, 32'd9, 32'd0, 0, 0, 33'h0_00000009, 32'hFFFFFFFF, 1, 1, "mod_zero");
`else
    issue(4'hA, 32'd100, 32'd7, 0, 0, 33'd0, 32'd0, 0, 1, "div_off");
`endif

    @(negedge clk);
    drive(4'h0, 32'h1, 32'h2, 0, 0);
    expect_rsp(33'h3, 0, 0, 1, "add_ld_held");
    @(negedge clk);
    @(negedge clk);
    ld = 0;
    chk("ld_at_done_busy", 64'(busy), 64'd0);
    drain();

    @(negedge clk);
    drive(4'h9, 32'h3, 32'h3, 0, 0);
    @(negedge clk);
    ld = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_res", 64'(res), 64'd0);
    chk("abort_res_hi", 64'(res_hi), 64'd0);
    repeat (40) @(negedge clk);

    issue(4'h0, 32'h10, 32'h20, 0, 0, 33'h30, 0, 0, 1, "add_pre_rst");
    rst = 1;
    drive(4'h0, 32'h1, 32'h1, 0, 0);
    @(negedge clk);
    rst = 0;
    ld = 0;
    chk("rst_ld_busy", 64'(busy), 64'd0);
    chk("rst_ld_res", 64'(res), 64'd0);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
